// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store request at a time, with a fixed response latency.
// Define DMEM_ERR_EN to report misaligned and out-of-range accesses as errors; otherwise they are aligned/wrapped.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [1:0]    size;
  logic          illegal;
  logic          err;
  logic          err_out_nxt;
  logic          store_en;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_data;
  logic [31:0]   rdata_nxt;

  assign accept = req_valid & req_ready;
  assign idx    = req_addr[AW+1:2];

  // Decode the access size and legality; lane may be forced aligned when errors are disabled.
  always_comb begin
    lane    = req_addr[1:0];
    size    = req_funct3[1:0];
    illegal = 1'b0;
    if (req_we) begin
      illegal = (req_funct3 > 3'd2);
    end else begin
      illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end
`ifdef DMEM_ERR_EN
    err = illegal
        | ((size == 2'd1) & lane[0])
        | ((size == 2'd2) & (lane != 2'd0))
        | ({2'b00, req_addr} >= (34'(DEPTH_WORDS) << 2));
    err_out_nxt = err;
`else
    if (size == 2'd1) lane[0] = 1'b0;
    if (size == 2'd2) lane    = 2'd0;
    err         = illegal;
    err_out_nxt = 1'b0;
`endif
  end

  // Byte-lane enables and replicated store data, then extended load data.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (size)
      2'd0: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'd2: be = 4'b1111;
      default: be = 4'b0000;
    endcase

    word   = mem[idx];
    byte_v = word[8*lane +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (req_funct3)
      3'd0:    load_data = {{24{byte_v[7]}}, byte_v};
      3'd1:    load_data = {{16{half_v[15]}}, half_v};
      3'd2:    load_data = word;
      3'd4:    load_data = {24'd0, byte_v};
      3'd5:    load_data = {16'd0, half_v};
      default: load_data = 32'd0;
    endcase
    rdata_nxt = (req_we | err) ? 32'd0 : load_data;
  end

  assign store_en = accept & req_we & ~err;

  // Array has no reset; stores commit on the accepting edge.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err_out_nxt;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef DMEM_ERR_EN
  // Upper address bits are deliberately ignored when addresses wrap.
  logic unused_addr;
  assign unused_addr = &{1'b0, req_addr[31:AW+2]};
`endif

endmodule
